// File: rtl/bcd_display_converter_if.sv
// Data/handshake bundle between the memory read-back stage and the BCD
// display converter.
//   din        : unsigned value to display
//   in_valid   : din valid this cycle
//   in_ready   : converter idle, din will be accepted
//   ones..thousands : BCD digits for the segment multiplexer
//   overflow   : last accepted value was saturated
//   done       : one-cycle pulse when the digits update
// master = producer/consumer side (memory stage + display mux),
// slave  = the converter itself.
interface bcd_display_converter_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] din;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        ones;
    logic [3:0]        tens;
    logic [3:0]        hundreds;
    logic [3:0]        thousands;
    logic              overflow;
    logic              done;

    modport master (
        output din, in_valid,
        input  in_ready, ones, tens, hundreds, thousands, overflow, done
    );

    modport slave (
        input  din, in_valid,
        output in_ready, ones, tens, hundreds, thousands, overflow, done
    );
endinterface

// File: rtl/bcd_display_converter.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Takes a DATA_W-bit unsigned word, saturates anything above MAX_VAL to
// MAX_VAL (raising overflow) and produces four BCD digits for the display.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : bcd_display_converter_if.slave (din/in_valid in; in_ready, digits,
//         overflow, done out)
// A conversion takes CONV_W shift cycles plus one DONE cycle; the digit
// registers are separate from the accumulator so partial results never show.
module bcd_display_converter #(
    parameter int DATA_W  = 32,
    parameter int CONV_W  = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic clk,
    input  logic rst,
    bcd_display_converter_if.slave bus
);
    localparam int CNT_W = $clog2(CONV_W);
    localparam logic [DATA_W-1:0] MAX_WIDE   = DATA_W'(MAX_VAL);
    localparam logic [CONV_W-1:0] MAX_NARROW = CONV_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(CONV_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CONV_W-1:0] bin_reg;
    logic [15:0]       bcd_reg;
    logic [15:0]       bcd_adj;
    logic [CNT_W-1:0]  cnt_reg;
    logic              pend_ovf_reg;
    logic [3:0]        ones_reg, tens_reg, hundreds_reg, thousands_reg;
    logic              overflow_reg;
    logic              done_reg;
    logic              idle_flag;
    logic              accept;
    logic              sat;

    // Add-3 correction on each nibble, all evaluated on pre-shift values.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Saturation looks at the whole input word, not just the converted bits.
    assign sat    = (bus.din > MAX_WIDE);
    assign accept = idle_flag && bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        idle_flag  = 1'b0;
        case (state_reg)
            IDLE: begin
                idle_flag = 1'b1;
                if (bus.in_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (cnt_reg == '0) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg      <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            pend_ovf_reg <= 1'b0;
        end else if (accept) begin
            bin_reg      <= sat ? MAX_NARROW : bus.din[CONV_W-1:0];
            bcd_reg      <= '0;
            cnt_reg      <= CNT_LOAD;
            pend_ovf_reg <= sat;
        end else if (state_reg == SHIFT) begin
            // Corrected accumulator and binary shift together; top bit drops.
            {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
            cnt_reg            <= cnt_reg - 1'b1;
        end
    end

    // Display registers: only updated from the finished accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_reg      <= '0;
            tens_reg      <= '0;
            hundreds_reg  <= '0;
            thousands_reg <= '0;
            overflow_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                ones_reg      <= bcd_reg[3:0];
                tens_reg      <= bcd_reg[7:4];
                hundreds_reg  <= bcd_reg[11:8];
                thousands_reg <= bcd_reg[15:12];
                overflow_reg  <= pend_ovf_reg;
            end
        end
    end

    assign bus.in_ready  = idle_flag;
    assign bus.ones      = ones_reg;
    assign bus.tens      = tens_reg;
    assign bus.hundreds  = hundreds_reg;
    assign bus.thousands = thousands_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.done      = done_reg;
endmodule

// File: tb/tb_bcd_display_converter.sv
module tb_bcd_display_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   conv_cnt = 0;

    always #5 clk = ~clk;

    bcd_display_converter_if #(.DATA_W(32)) bus ();

    bcd_display_converter #(
        .DATA_W (32),
        .CONV_W (14),
        .MAX_VAL(9999)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // done is a full-cycle pulse, so one negedge sample per pulse
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference: saturate, then split into decimal digits arithmetically.
    function automatic logic [15:0] ref_bcd(input logic [31:0] v);
        int s;
        s = (v > 32'd9999) ? 9999 : int'(v);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] digits();
        return {bus.thousands, bus.hundreds, bus.tens, bus.ones};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present v at a negedge once ready, leave at 1ns after the accept edge.
    task automatic send(input logic [31:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait_bound", 32'(n < 40), 32'd1);
        bus.din      = v;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.din      = $urandom;  // must not disturb the conversion in flight
        chk("busy_after_accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done !== 1'b1 && bus.in_ready !== 1'b0)
                chk("ready_low_while_busy", 32'(bus.in_ready), 32'd0);
        end while (bus.done !== 1'b1 && cyc < 40);
    endtask

    task automatic check_result(input string tag, input logic [31:0] v);
        chk({tag, "_digits"}, 32'(digits()), 32'(ref_bcd(v)));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(v > 32'd9999));
        $display("conv %s din=%0d digits=%h ovf=%0b", tag, v, digits(), bus.overflow);
    endtask

    task automatic run_one(input string tag, input logic [31:0] v);
        int cyc;
        send(v);
        wait_done(cyc);
        conv_cnt++;
        chk({tag, "_latency"}, 32'(cyc), 32'd15);
        check_result(tag, v);
        chk({tag, "_ready_at_done"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int cyc;
        int base;
        logic [31:0] v;
        logic [31:0] edges [10] = '{0, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000};

        // in_valid during reset is ignored
        bus.din      = 32'd55;
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_digits", 32'(digits()), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_done", 32'(done_cnt), 32'd0);

        run_one("d1234", 32'd1234);

        // back-to-back with in_valid held high
        @(negedge clk);
        bus.din      = 32'd0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_accept0", 32'(bus.in_ready), 32'd0);
        bus.din = 32'd9999;
        wait_done(cyc);
        conv_cnt++;
        chk("b2b0_latency", 32'(cyc), 32'd15);
        check_result("b2b0", 32'd0);
        chk("b2b_ready_at_done", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("b2b_accept1", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        wait_done(cyc);
        conv_cnt++;
        chk("b2b1_latency", 32'(cyc), 32'd15);
        check_result("b2b1", 32'd9999);

        run_one("sat10000", 32'd10000);
        run_one("satmax", 32'hFFFF_FFFF);
        run_one("d7", 32'd7);

        // in_valid pulses during SHIFT are dropped
        base = done_cnt;
        send(32'd5678);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.din      = 32'd4321;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(cyc);
        conv_cnt++;
        chk("drop_latency", 32'(cyc), 32'd6);
        check_result("drop", 32'd5678);
        repeat (20) @(posedge clk);
        #1;
        chk("drop_single_done", 32'(done_cnt - base), 32'd1);

        // asynchronous reset mid-SHIFT
        send(32'd8080);
        base = done_cnt;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_digits", 32'(digits()), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt - base), 32'd0);
        run_one("d42", 32'd42);

        for (int i = 0; i < 10; i++) run_one("edge", edges[i]);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom;
            else                           v = 32'($urandom_range(0, 9999));
            run_one("rand", v);
        end

        // every completed conversion since the reset abort gave one pulse
        chk("done_total", 32'(done_cnt), 32'(conv_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
